alu_accumulator: RTL and testbench

ALU_ACCUMULATOR -- requirements
Module: alu_accumulator

---
 rtl/alu_accumulator.sv | 177 +++++++++++++++++
 tb/tb_alu_accumulator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_accumulator.sv
// 4-bit accumulator ALU: single-cycle add/sub/and/shift/load, 4-cycle shift-add multiply and
// optional 4-cycle restoring divide (enabled by macro ALU_DIV_EN); strobes ignored while busy.
module alu_accumulator (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] bus_in,
  input  logic [3:0] breg,
  input  logic       ah_inen,
  input  logic       ah_reset,
  input  logic       adds,
  input  logic       subs,
  input  logic       ands,
  input  logic       muls,
  input  logic       divs,
  input  logic [1:0] hs,
  input  logic [1:0] ls,
  input  logic       acc_oen,
  output logic [3:0] acc_out,
  output logic [3:0] al_out,
  output logic       z_f,
  output logic       s_f,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    MUL
`ifdef ALU_DIV_EN
    , DIV
`endif
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] ah, ah_nxt, al, al_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       z_nxt, s_nxt, busy_nxt, done_nxt;

  logic [3:0] add_res, sub_res, and_res;
  logic [4:0] mul_sum;
  logic [3:0] mul_ah, mul_al;

  assign add_res = ah + breg;
  assign sub_res = ah - breg;
  assign and_res = ah & breg;

  // One multiplier bit per cycle: add breg if AL[0], then shift {carry,AH,AL} right.
  assign mul_sum = {1'b0, ah} + (al[0] ? {1'b0, breg} : 5'd0);
  assign mul_ah  = mul_sum[4:1];
  assign mul_al  = {mul_sum[0], al[3:1]};

`ifdef ALU_DIV_EN
  logic [4:0] div_rem;
  logic       div_ge;
  logic [3:0] div_sub, div_ah, div_al;

  // With breg=0 every step "subtracts" nothing, so AL fills with ones and AH ends as AL_initial.
  assign div_rem = {ah, al[3]};
  assign div_ge  = (div_rem >= {1'b0, breg});
  assign div_sub = div_rem[3:0] - breg;
  assign div_ah  = div_ge ? div_sub : div_rem[3:0];
  assign div_al  = {al[2:0], div_ge};
`endif

  always_comb begin
    state_nxt = state;
    ah_nxt    = ah;
    al_nxt    = al;
    cnt_nxt   = cnt;
    z_nxt     = z_f;
    s_nxt     = s_f;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (ah_reset) begin
          ah_nxt = 4'h0;
        end else if (ah_inen) begin
          ah_nxt = bus_in;
        end else if (muls) begin
          state_nxt = MUL;
          ah_nxt    = 4'h0;
          cnt_nxt   = 3'd0;
          busy_nxt  = 1'b1;
        end else if (divs) begin
`ifdef ALU_DIV_EN
          state_nxt = DIV;
          ah_nxt    = 4'h0;
          cnt_nxt   = 3'd0;
          busy_nxt  = 1'b1;
`endif
        end else if (adds) begin
          ah_nxt = add_res;
          z_nxt  = (add_res == 4'h0);
          s_nxt  = add_res[3];
        end else if (subs) begin
          ah_nxt = sub_res;
          z_nxt  = (sub_res == 4'h0);
          s_nxt  = sub_res[3];
        end else if (ands) begin
          ah_nxt = and_res;
          z_nxt  = (and_res == 4'h0);
          s_nxt  = and_res[3];
        end else begin
          case (hs)
            2'b01:   ah_nxt = {ah[2:0], al[3]};
            2'b10:   ah_nxt = {1'b0, ah[3:1]};
            2'b11:   ah_nxt = bus_in;
            default: ah_nxt = ah;
          endcase
          case (ls)
            2'b01:   al_nxt = {al[2:0], 1'b0};
            2'b10:   al_nxt = {ah[0], al[3:1]};
            2'b11:   al_nxt = bus_in;
            default: al_nxt = al;
          endcase
        end
      end
      MUL: begin
        ah_nxt  = mul_ah;
        al_nxt  = mul_al;
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd3) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          z_nxt     = ({mul_ah, mul_al} == 8'h00);
          s_nxt     = mul_ah[3];
        end
      end
`ifdef ALU_DIV_EN
      DIV: begin
        ah_nxt  = div_ah;
        al_nxt  = div_al;
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd3) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          z_nxt     = (breg == 4'h0) ? 1'b0 : (div_al == 4'h0);
          s_nxt     = (breg == 4'h0);
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      ah    <= 4'h0;
      al    <= 4'h0;
      cnt   <= 3'd0;
      z_f   <= 1'b1;
      s_f   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ah    <= ah_nxt;
      al    <= al_nxt;
      cnt   <= cnt_nxt;
      z_f   <= z_nxt;
      s_f   <= s_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  assign acc_out = acc_oen ? ah : 4'h0;
  assign al_out  = al;

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator: reset, arithmetic wrap, shifts, multiply, busy-ignore,
// abort, done-cycle acceptance and divide (or divide no-op when ALU_DIV_EN is undefined).
module tb_alu_accumulator;
  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] bus_in, breg;
  logic       ah_inen, ah_reset, adds, subs, ands, muls, divs;
  logic [1:0] hs, ls;
  logic       acc_oen;
  logic [3:0] acc_out, al_out;
  logic       z_f, s_f, busy, done;
  int         checks = 0;
  int         errors = 0;

  alu_accumulator dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .breg(breg),
    .ah_inen(ah_inen), .ah_reset(ah_reset), .adds(adds), .subs(subs), .ands(ands),
    .muls(muls), .divs(divs), .hs(hs), .ls(ls), .acc_oen(acc_oen),
    .acc_out(acc_out), .al_out(al_out), .z_f(z_f), .s_f(s_f), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ah_inen = 0; ah_reset = 0; adds = 0; subs = 0; ands = 0; muls = 0; divs = 0;
    hs = 2'b00; ls = 2'b00;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with random inputs
    clr = 0; acc_oen = 1'($urandom); bus_in = 4'($urandom); breg = 4'($urandom);
    ah_inen = 1'($urandom); ah_reset = 1'($urandom); adds = 1'($urandom); subs = 1'($urandom);
    ands = 1'($urandom); muls = 1'($urandom); divs = 1'($urandom);
    hs = 2'($urandom); ls = 2'($urandom);
    step();
    acc_oen = 1; #1;
    chk("rst_ah", 8'(acc_out), 8'h0);
    chk("rst_al", 8'(al_out), 8'h0);
    chk("rst_z", 8'(z_f), 8'h1);
    chk("rst_s", 8'(s_f), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    clr = 1; idle_inputs(); bus_in = 0; breg = 0;

    // Subtract wrap, and, add wrap
    ah_inen = 1; bus_in = 4'h1; step(); ah_inen = 0;
    breg = 4'h2; subs = 1; step(); subs = 0;
    chk("sub_ah", 8'(acc_out), 8'hF);
    chk("sub_z", 8'(z_f), 8'h0);
    chk("sub_s", 8'(s_f), 8'h1);
    breg = 4'hA; ands = 1; step(); ands = 0;
    chk("and_ah", 8'(acc_out), 8'hA);
    ah_inen = 1; bus_in = 4'hC; step(); ah_inen = 0;
    chk("load_ah", 8'(acc_out), 8'hC);
    chk("load_flags", {6'd0, z_f, s_f}, 8'h1);
    breg = 4'h4; adds = 1; step(); adds = 0;
    chk("add_ah", 8'(acc_out), 8'h0);
    chk("add_z", 8'(z_f), 8'h1);
    chk("add_s", 8'(s_f), 8'h0);

    // Shift chain
    ah_inen = 1; bus_in = 4'h9; step(); ah_inen = 0;
    ls = 2'b11; bus_in = 4'h6; step();
    chk("ldal_al", 8'(al_out), 8'h6);
    hs = 2'b01; ls = 2'b01; step();
    chk("shl_ah", 8'(acc_out), 8'h2);
    chk("shl_al", 8'(al_out), 8'hC);
    acc_oen = 0; #1;
    chk("oen_off", 8'(acc_out), 8'h0);
    acc_oen = 1;
    hs = 2'b10; ls = 2'b10; step(); hs = 0; ls = 0;
    chk("shr_ah", 8'(acc_out), 8'h1);
    chk("shr_al", 8'(al_out), 8'h6);
    chk("shift_flags", {6'd0, z_f, s_f}, 8'h2);

    // Multiply F*F
    ls = 2'b11; bus_in = 4'hF; step(); ls = 0;
    breg = 4'hF; muls = 1; step(); muls = 0;
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy", 8'(busy), 8'h1);
      chk("mul_nodone", 8'(done), 8'h0);
      step();
    end
    chk("mul_busy_end", 8'(busy), 8'h0);
    chk("mul_done", 8'(done), 8'h1);
    chk("mul_prod", {acc_out, al_out}, 8'hE1);
    chk("mul_flags", {6'd0, z_f, s_f}, 8'h1);
    step();
    chk("mul_done_pulse", 8'(done), 8'h0);

    // Multiply 3*5 with strobes ignored while busy, then add accepted in done cycle
    ls = 2'b11; bus_in = 4'h3; step(); ls = 0;
    breg = 4'h5; muls = 1; step(); muls = 0;
    adds = 1; ah_reset = 1; ah_inen = 1; bus_in = 4'hA; hs = 2'b11; ls = 2'b11;
    step(); step(); step();
    idle_inputs();
    step();
    chk("mul2_done", 8'(done), 8'h1);
    chk("mul2_prod", {acc_out, al_out}, 8'h0F);
    chk("mul2_flags", {6'd0, z_f, s_f}, 8'h0);
    adds = 1; step(); adds = 0;
    chk("done_accept_ah", 8'(acc_out), 8'h5);
    chk("done_accept_done", 8'(done), 8'h0);

    // Abort multiply with clr in cycle 2
    ls = 2'b11; bus_in = 4'h7; step(); ls = 0;
    breg = 4'h3; muls = 1; step(); muls = 0;
    step();
    chk("abort_busy_pre", 8'(busy), 8'h1);
    clr = 0; step(); clr = 1;
    chk("abort_regs", {acc_out, al_out}, 8'h00);
    chk("abort_flags", {4'd0, z_f, s_f, busy, done}, 8'h8);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_nodone", {6'd0, busy, done}, 8'h0);
    end

`ifdef ALU_DIV_EN
    // Divide 13/3 and divide by zero
    ls = 2'b11; bus_in = 4'hD; step(); ls = 0;
    breg = 4'h3; divs = 1; step(); divs = 0;
    chk("div_busy", 8'(busy), 8'h1);
    step(); step(); step(); step();
    chk("div_done", 8'(done), 8'h1);
    chk("div_res", {acc_out, al_out}, 8'h14);
    chk("div_flags", {6'd0, z_f, s_f}, 8'h0);
    ls = 2'b11; bus_in = 4'hD; step(); ls = 0;
    breg = 4'h0; divs = 1; step(); divs = 0;
    step(); step(); step(); step();
    chk("div0_done", 8'(done), 8'h1);
    chk("div0_res", {acc_out, al_out}, 8'hDF);
    chk("div0_flags", {6'd0, z_f, s_f}, 8'h1);
`else
    // Divide strobe is a no-op without the divider
    ah_inen = 1; bus_in = 4'h7; step(); ah_inen = 0;
    ls = 2'b11; bus_in = 4'hD; step(); ls = 0;
    breg = 4'h3; divs = 1; step(); divs = 0;
    chk("nodiv_busy", 8'(busy), 8'h0);
    chk("nodiv_regs", {acc_out, al_out}, 8'h7D);
    step();
    chk("nodiv_done", 8'(done), 8'h0);
    chk("nodiv_regs2", {acc_out, al_out}, 8'h7D);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
